// File: rtl/mult_unit_pkg.sv
// Datapath-wide definitions shared by the multiplier and the control unit decode.
// Holds the sequencer state encodings, the Booth step count and the MULT funct code.
package mult_unit_pkg;

  typedef enum logic {
    MULT_ST_IDLE = 1'b0,
    MULT_ST_RUN  = 1'b1
  } mult_state_e;

  localparam int MULT_STEPS = 32;

  // R-type funct field that selects MULT; the control unit decodes the same value
  localparam logic [5:0] FUNCT_MULT = 6'h18;

endpackage

// File: rtl/mult_unit_if.sv
// Handshake and operand/result bundle between the control unit and the multiplier.
// The control unit is the master; the multiplier is the slave.
interface mult_unit_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output start, a_in, b_in,
    input  busy, done, hi_out, lo_out
  );

  modport slave (
    input  start, a_in, b_in,
    output busy, done, hi_out, lo_out
  );

endinterface

// File: rtl/mult_unit_booth_step.sv
// One combinational radix-2 Booth step: conditional add/sub of M into A, then an
// arithmetic right shift of {A,Q,Q_1} using the sign of the post-add accumulator.
module booth_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   i_a,
  input  logic [WIDTH-1:0] i_q,
  input  logic             i_q1,
  input  logic [WIDTH:0]   i_m,
  output logic [WIDTH:0]   o_a,
  output logic [WIDTH-1:0] o_q,
  output logic             o_q1
);

  logic [WIDTH:0] w_sum;

  always_comb begin
    w_sum = i_a;
    case ({i_q[0], i_q1})
      2'b01:   w_sum = i_a + i_m;
      2'b10:   w_sum = i_a - i_m;
      default: w_sum = i_a;
    endcase
  end

  // A carries one extra sign bit, so the sum never overflows even for M = -2^(WIDTH-1)
  assign o_a  = {w_sum[WIDTH], w_sum[WIDTH:1]};
  assign o_q  = {w_sum[0], i_q[WIDTH-1:1]};
  assign o_q1 = i_q[0];

endmodule

// File: rtl/mult_unit.sv
// Multicycle signed WIDTHxWIDTH multiplier for the MULT instruction.
// Sequences MULT_STEPS Booth steps and registers the product for HI/LO writeback.
module mult_unit
  import mult_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic        clk,
  input logic        reset,
  mult_unit_if.slave bus
);

  localparam logic [5:0] LAST_STEP = 6'(MULT_STEPS - 1);

  mult_state_e      r_state;
  logic [WIDTH:0]   r_a;
  logic [WIDTH:0]   r_m;
  logic [WIDTH-1:0] r_q;
  logic             r_q1;
  logic [5:0]       r_count;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic [WIDTH:0]   w_a;
  logic [WIDTH-1:0] w_q;
  logic             w_q1;

  booth_step #(
    .WIDTH(WIDTH)
  ) u_booth_step (
    .i_a  (r_a),
    .i_q  (r_q),
    .i_q1 (r_q1),
    .i_m  (r_m),
    .o_a  (w_a),
    .o_q  (w_q),
    .o_q1 (w_q1)
  );

  // Operands are sampled only on the accepting edge; start during RUN is dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= MULT_ST_IDLE;
      r_a     <= '0;
      r_m     <= '0;
      r_q     <= '0;
      r_q1    <= 1'b0;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        MULT_ST_IDLE: begin
          if (bus.start) begin
            r_a     <= '0;
            r_q     <= bus.b_in;
            r_q1    <= 1'b0;
            r_m     <= {bus.a_in[WIDTH-1], bus.a_in};
            r_count <= '0;
            r_busy  <= 1'b1;
            r_state <= MULT_ST_RUN;
          end
        end
        MULT_ST_RUN: begin
          r_a     <= w_a;
          r_q     <= w_q;
          r_q1    <= w_q1;
          r_count <= r_count + 6'd1;
          if (r_count == LAST_STEP) begin
            r_hi    <= w_a[WIDTH-1:0];
            r_lo    <= w_q;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= MULT_ST_IDLE;
          end
        end
        default: r_state <= MULT_ST_IDLE;
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.hi_out = r_hi;
  assign bus.lo_out = r_lo;

endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: products are predicted with native signed
// multiplication, queued at launch and compared when done pulses.
module tb_mult_unit;

  localparam int W       = 32;
  localparam int LATENCY = 32;
  localparam int TIMEOUT = 40;

  logic clk;
  logic reset;
  int   nChecks;
  int   nFails;
  int   cyc;
  int   startCyc;
  logic [63:0] expQ[$];

  mult_unit_if #(.WIDTH(W)) ifc ();

  mult_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Advance n rising edges and settle 1ns past the last one
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a start pulse for one edge and queue the expected signed product
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    sa = 64'(signed'(a));
    sb = 64'(signed'(b));
    ifc.a_in  = a;
    ifc.b_in  = b;
    ifc.start = 1'b1;
    expQ.push_back(sa * sb);
    tick(1);
    ifc.start = 1'b0;
    startCyc  = cyc;
  endtask

  // Wait for done with a bound; also checks hi/lo stay frozen while running
  task automatic wait_done(input string name, output logic seen);
    logic [W-1:0] holdHi;
    logic [W-1:0] holdLo;
    logic         moved;
    holdHi = ifc.hi_out;
    holdLo = ifc.lo_out;
    moved  = 1'b0;
    seen   = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      if (ifc.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (ifc.hi_out !== holdHi || ifc.lo_out !== holdLo) moved = 1'b1;
      tick(1);
    end
    nChecks++;
    if (moved) begin
      nFails++;
      $display("[TB] FAIL %s hold: hi/lo changed during RUN, got %h_%h required %h_%h",
               name, ifc.hi_out, ifc.lo_out, holdHi, holdLo);
    end
    nChecks++;
    if (!seen) begin
      nFails++;
      $display("[TB] FAIL %s timeout: done=%b after %0d cycles, required 1", name, ifc.done, TIMEOUT);
    end
  endtask

  // Compare latency and the popped scoreboard entry against hi/lo in the done cycle
  task automatic check_result(input string name);
    logic [63:0] exp;
    nChecks++;
    if ((cyc - startCyc) !== LATENCY) begin
      nFails++;
      $display("[TB] FAIL %s latency: got %0d required %0d", name, cyc - startCyc, LATENCY);
    end
    nChecks++;
    if (expQ.size() == 0) begin
      nFails++;
      $display("[TB] FAIL %s scoreboard: got empty queue required one entry", name);
    end else begin
      exp = expQ.pop_front();
      if ({ifc.hi_out, ifc.lo_out} !== exp) begin
        nFails++;
        $display("[TB] FAIL %s product: got %h_%h required %h_%h",
                 name, ifc.hi_out, ifc.lo_out, exp[63:32], exp[31:0]);
      end
    end
  endtask

  task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b, input string name);
    logic seen;
    launch(a, b);
    nChecks++;
    if (ifc.busy !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL %s busy: got %b required 1", name, ifc.busy);
    end
    wait_done(name, seen);
    if (seen) check_result(name);
    tick(1);
    nChecks++;
    if (ifc.done !== 1'b0 || ifc.busy !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL %s after_done: got done=%b busy=%b required 0 0", name, ifc.done, ifc.busy);
    end
  endtask

  task automatic count_quiet(input string name);
    int pulses;
    pulses = 0;
    for (int i = 0; i < TIMEOUT; i++) begin
      if (ifc.done === 1'b1) pulses++;
      tick(1);
    end
    nChecks++;
    if (pulses != 0) begin
      nFails++;
      $display("[TB] FAIL %s no_done: got %0d pulses required 0", name, pulses);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    nChecks++;
    if ({ifc.busy, ifc.done, ifc.hi_out, ifc.lo_out} !== {2'b00, 64'h0}) begin
      nFails++;
      $display("[TB] FAIL reset_state: got busy=%b done=%b hi=%h lo=%h required 0 0 0 0",
               ifc.busy, ifc.done, ifc.hi_out, ifc.lo_out);
    end
    count_quiet("reset_idle");
  endtask

  task automatic test_basic();
    run_one(32'd3, 32'd5, "basic_3x5");
    nChecks++;
    if ({ifc.hi_out, ifc.lo_out} !== 64'h0000_0000_0000_000F) begin
      nFails++;
      $display("[TB] FAIL basic_hold: got %h_%h required 00000000_0000000f", ifc.hi_out, ifc.lo_out);
    end
  endtask

  task automatic test_signed();
    run_one(32'hFFFF_FFF9, 32'd6, "signed_m7x6");
    run_one(32'd6, 32'hFFFF_FFF9, "signed_6xm7");
    run_one(32'h1234_5678, 32'hFEDC_BA98, "signed_mixed");
    for (int i = 0; i < 4; i++) run_one($urandom, $urandom, "signed_random");
  endtask

  task automatic test_extremes();
    run_one(32'h8000_0000, 32'h8000_0000, "ext_min_min");
    run_one(32'h7FFF_FFFF, 32'h8000_0000, "ext_max_min");
    run_one(32'hFFFF_FFFF, 32'hFFFF_FFFF, "ext_m1_m1");
    run_one(32'h7FFF_FFFF, 32'h7FFF_FFFF, "ext_max_max");
    run_one(32'h0000_0000, 32'h8000_0000, "ext_zero");
  endtask

  task automatic test_protocol();
    logic seen;
    int   pulses;
    launch(32'd2, 32'd3);
    tick(9);
    ifc.a_in  = 32'd9;
    ifc.b_in  = 32'd9;
    ifc.start = 1'b1;
    tick(1);
    ifc.start = 1'b0;
    wait_done("proto_ignore", seen);
    if (seen) check_result("proto_ignore");
    // Start in the done cycle must be accepted immediately
    launch(32'd4, 32'd4);
    nChecks++;
    if (ifc.done !== 1'b0 || ifc.busy !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL proto_start_in_done: got done=%b busy=%b required 0 1", ifc.done, ifc.busy);
    end
    pulses = 0;
    for (int i = 0; i < LATENCY - 1; i++) begin
      if (ifc.done === 1'b1) pulses++;
      tick(1);
    end
    nChecks++;
    if (pulses != 0) begin
      nFails++;
      $display("[TB] FAIL proto_single_done: got %0d extra pulses required 0", pulses);
    end
    wait_done("proto_back_to_back", seen);
    if (seen) check_result("proto_back_to_back");
    tick(1);
  endtask

  task automatic test_reset_mid();
    logic seen;
    launch(32'd5, 32'd5);
    tick(14);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    expQ.delete();
    nChecks++;
    if ({ifc.busy, ifc.done, ifc.hi_out, ifc.lo_out} !== {2'b00, 64'h0}) begin
      nFails++;
      $display("[TB] FAIL reset_mid: got busy=%b done=%b hi=%h lo=%h required 0 0 0 0",
               ifc.busy, ifc.done, ifc.hi_out, ifc.lo_out);
    end
    count_quiet("reset_mid_quiet");
    run_one(32'd5, 32'd5, "reset_mid_restart");
    seen = 1'b0;
  endtask

  initial begin
    nChecks   = 0;
    nFails    = 0;
    cyc       = 0;
    startCyc  = 0;
    reset     = 1'b1;
    ifc.start = 1'b0;
    ifc.a_in  = '0;
    ifc.b_in  = '0;
    test_reset();
    test_basic();
    test_signed();
    test_extremes();
    test_protocol();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/mult_unit.md
Name: mult_unit

Overview:
- Multicycle signed 32x32 multiplier (radix-2 Booth) on the datapath side of the control unit. Executes the MULT instruction.
- The control unit pulses start with A/B register contents on the operand inputs, then waits on done.
- The 64-bit product goes to the HI/LO registers. Writeback is enabled by the control unit on done.

Parameters:
- WIDTH, 32, operand width; product width is 2*WIDTH.
- Only the default is verified.

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- start  input  1  request: capture operands and begin multiply
- a_in  input  WIDTH  multiplicand (signed, two's complement)
- b_in  input  WIDTH  multiplier (signed, two's complement)
- busy  output  1  high while an operation is in progress
- done  output  1  single-cycle pulse: hi_out/lo_out valid
- hi_out  output  WIDTH  product bits [2*WIDTH-1:WIDTH]
- lo_out  output  WIDTH  product bits [WIDTH-1:0]

Behaviour:
- Reset: when reset is high at an edge:
  - state=IDLE; busy=0, done=0, hi_out=0, lo_out=0.
  - Internal A, Q, Q_1, M and count are cleared.
  - Any operation in flight is aborted with no done.
- Internal registers:
  - A: WIDTH+1 bits, sign-extended accumulator; this avoids overflow when M = -2^(WIDTH-1).
  - Q: WIDTH bits.
  - Q_1: 1 bit.
  - M: WIDTH+1 bits, sign-extended a_in.
  - count: 6 bits.
- States: IDLE, RUN. Encoding is 1 bit; busy is registered and equals (state==RUN).
- IDLE, start=1 at edge k:
  - Load A=0, Q=b_in, Q_1=0, M=sext(a_in), count=0.
  - state=RUN, busy=1.
  - Operands are sampled only at this edge; later changes on a_in/b_in are ignored.
- RUN, each edge: one Booth step.
  - {Q[0],Q_1}=01: A=A+M.
  - {Q[0],Q_1}=10: A=A-M.
  - 00/11: no add.
  - Then arithmetic right shift of {A,Q,Q_1} by one bit, using the sign bit of the post-add A.
  - count increments.
- The 32nd step happens at edge k+32 (count==31 before that edge). At that edge:
  - hi_out/lo_out take the final {A[WIDTH-1:0],Q} after the shift.
  - done=1, busy=0, state=IDLE.
- Latency: done is high for exactly the cycle after edge k+32, i.e. 32 cycles after start was accepted. It deasserts on the next edge.
- hi_out/lo_out hold their value until the next completion or reset. They do not change during RUN.
- start while RUN: ignored, with no queueing.
- start in the cycle where done=1: accepted, since state is already IDLE. done still drops on that edge, and busy rises.
- start and reset both high: reset wins.
- Arithmetic: the result is the exact signed 64-bit product for all operand pairs, including -2^31 * -2^31.
- There is no overflow flag; MULT never raises an exception.

Decomposition:
- Shared package (the datapath-wide defs file) holds:
  - MULT_ST_IDLE / MULT_ST_RUN encodings.
  - The MULT_STEPS=32 constant.
  - The MULT funct code, also used by the control unit decode.
- One sub-module is natural: booth_step. It is combinational and takes A, Q, Q_1, M. It returns the next A, Q, Q_1 after the add/sub and arithmetic shift. Instantiated once.
- The sequencer, counter and output registers remain in mult_unit.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, then 0 → busy=0, done=0, hi_out=0, lo_out=0. done stays 0 for 40 cycles with start=0.
- Basic: a_in=3, b_in=5, start pulsed at edge k → busy=1 from k, done=1 exactly in cycle after edge k+32. Result hi_out=0x00000000, lo_out=0x0000000F.
- Signed: a_in=-7 (0xFFFFFFF9), b_in=6 → hi_out=0xFFFFFFFF, lo_out=0xFFFFFFD6.
- Extremes:
  - 0x80000000*0x80000000 → hi=0x40000000, lo=0x00000000.
  - 0x7FFFFFFF*0x80000000 → hi=0xC0000000, lo=0x80000000.
  - 0xFFFFFFFF*0xFFFFFFFF → hi=0, lo=1.
- Protocol:
  - Start 2*3. Re-pulse start with 9*9 and change a_in/b_in at cycle k+10 → ignored; result 6, done only once.
  - Then assert start in the done cycle with 4*4 → accepted. The next done comes 32 cycles later with lo=16.
- Reset mid-operation: start 5*5, reset at edge k+15 → busy=0 and hi/lo=0 immediately. No done appears in the following 40 cycles. A fresh start of 5*5 then completes with lo=25.
